mux_nx1_rr: RTL

- Parametrised N:1 registered multiplexer with per-input valid/ready handshake and a one-entry output register.
- Two modes:
  - Explicit select, the generalisation of the 2:1 mux.
  - Round-robin arbitration across all valid inputs.
- Sits in the datapath where several producers (lanes, memory ports, writeback sources) share one consumer.

---
 rtl/mux_nx1_rr_pkg.sv | 26 ++
 rtl/mux_nx1_rr_if.sv | 46 ++++
 rtl/mux_nx1_rr_rr_arbiter.sv | 44 ++++
 rtl/mux_nx1_rr.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux_nx1_rr_pkg.sv
// Shared types and constants for the N:1 registered round-robin multiplexer.
// Package mux_pkg is imported by the interface, the top and the testbench.
package mux_pkg;

  // Operating mode of the multiplexer.
  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_t;

  // Largest supported input count.
  localparam int MUX_MAX_N   = 16;
  // Width of each per-input grant counter (optional feature).
  localparam int GRANT_CNT_W = 16;

  // Increment an index modulo n.
  // The wrap is written out explicitly so that non-power-of-two N works.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Handshake/data bundle between the producers, the mux and the consumer.
// The slave modport is the multiplexer's view; master is the environment's.
// Optional macro MUX_GRANT_COUNT_EN adds the flattened GRANT_COUNT vector.
interface mux_nx1_rr_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) ();

  localparam int SEL_W = $clog2(N);

  logic                 MODE;
  logic [SEL_W-1:0]     SELECT;
  logic [N-1:0]         VALID_IN;
  logic [N*WIDTH-1:0]   DATA_IN;
  logic [N-1:0]         READY_OUT;
  logic                 VALID_OUT;
  logic [WIDTH-1:0]     DATA_OUT;
  logic [SEL_W-1:0]     SRC_OUT;
  logic                 READY_IN;
`ifdef MUX_GRANT_COUNT_EN
  logic [N*GRANT_CNT_W-1:0] GRANT_COUNT;
`endif

`ifdef MUX_GRANT_COUNT_EN
  modport slave (
    input  MODE, SELECT, VALID_IN, DATA_IN, READY_IN,
    output READY_OUT, VALID_OUT, DATA_OUT, SRC_OUT, GRANT_COUNT
  );
  modport master (
    output MODE, SELECT, VALID_IN, DATA_IN, READY_IN,
    input  READY_OUT, VALID_OUT, DATA_OUT, SRC_OUT, GRANT_COUNT
  );
`else
  modport slave (
    input  MODE, SELECT, VALID_IN, DATA_IN, READY_IN,
    output READY_OUT, VALID_OUT, DATA_OUT, SRC_OUT
  );
  modport master (
    output MODE, SELECT, VALID_IN, DATA_IN, READY_IN,
    input  READY_OUT, VALID_OUT, DATA_OUT, SRC_OUT
  );
`endif

endinterface

// File: rtl/mux_nx1_rr_rr_arbiter.sv
// Combinational N-wide round-robin arbiter.
// Scans ptr, ptr+1, ... (mod N) and grants the first requester when enabled.
// Produces a one-hot grant, the binary index of the winner and a valid flag.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt_oh,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // One extra bit so ptr + k (at most 2N-2) never overflows before the wrap.
  logic [SEL_W:0] cand_s;
  logic           found_s;

  // Rotating priority scan starting at the pointer.
  always_comb begin
    cand_s  = '0;
    found_s = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand_s >= (SEL_W+1)'(N)) begin
        cand_s = cand_s - (SEL_W+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (en && !found_s && req[cand_s[SEL_W-1:0]]) begin
        found_s                         = 1'b1;
        gnt_oh[cand_s[SEL_W-1:0]]       = 1'b1;
        gnt_idx                         = cand_s[SEL_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    gnt_valid = found_s;
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N:1 registered multiplexer with per-input valid/ready.
// MODE=0 takes the input named by SELECT, MODE=1 arbitrates round-robin.
// A one-entry output register allows one accept per cycle with no bubble.
// Optional macro MUX_GRANT_COUNT_EN adds one 16-bit transfer counter per input.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RESET,
  mux_nx1_rr_if.slave    bus
);

  mux_mode_t          mode_s;
  logic               free_s;
  logic               grant_en_s;
  logic [N-1:0]       sel_oh_s;
  logic [N-1:0]       arb_oh_s;
  logic [SEL_W-1:0]   arb_idx_s;
  logic               arb_vld_s;
  logic               arb_en_s;
  logic [N-1:0]       gnt_oh_s;
  logic [SEL_W-1:0]   gnt_idx_s;
  logic               gnt_vld_s;
  logic [WIDTH-1:0]   data_sel_s;

  logic               valid_r;
  logic [WIDTH-1:0]   data_r;
  logic [SEL_W-1:0]   src_r;
  logic [SEL_W-1:0]   ptr_r;

  assign mode_s = mux_mode_t'(bus.MODE);

  // The register can take a word when empty or when its word leaves this cycle.
  // Reset suppresses every grant so READY_OUT is low while RESET is high.
  assign free_s     = !valid_r || bus.READY_IN;
  assign grant_en_s = free_s && !RESET;
  assign arb_en_s   = grant_en_s && (mode_s == MODE_RR);

  // Explicit-select candidate; an out-of-range SELECT matches no input.
  always_comb begin
    sel_oh_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh_s[i] = (bus.SELECT == SEL_W'(i)) && bus.VALID_IN[i];
    end
  end

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req       (bus.VALID_IN),
    .ptr       (ptr_r),
    .en        (arb_en_s),
    .gnt_oh    (arb_oh_s),
    .gnt_idx   (arb_idx_s),
    .gnt_valid (arb_vld_s)
  );

  // Pick the grant source according to the current mode.
  always_comb begin
    gnt_oh_s  = '0;
    gnt_idx_s = '0;
    gnt_vld_s = 1'b0;
    case (mode_s)
      MODE_SELECT: begin
        gnt_oh_s  = grant_en_s ? sel_oh_s : '0;
        gnt_idx_s = bus.SELECT;
        gnt_vld_s = grant_en_s && (|sel_oh_s);
      end
      MODE_RR: begin
        gnt_oh_s  = arb_oh_s;
        gnt_idx_s = arb_idx_s;
        gnt_vld_s = arb_vld_s;
      end
      default: begin
        gnt_oh_s  = '0;
        gnt_idx_s = '0;
        gnt_vld_s = 1'b0;
      end
    endcase
  end

  // One-hot data mux driven directly by the grant vector.
  always_comb begin
    data_sel_s = '0;
    for (int i = 0; i < N; i++) begin
      data_sel_s = gnt_oh_s[i] ? bus.DATA_IN[i*WIDTH +: WIDTH] : data_sel_s;
    end
  end

  assign bus.READY_OUT = gnt_oh_s;

  // Output register: load on grant, empty on consume, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      src_r   <= '0;
    end else if (gnt_vld_s) begin
      valid_r <= 1'b1;
      data_r  <= data_sel_s;
      src_r   <= gnt_idx_s;
    end else if (bus.READY_IN && valid_r) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
      src_r   <= src_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
      src_r   <= src_r;
    end
  end

  // Round-robin pointer moves past the winner only on round-robin grants.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_r <= '0;
    end else if (gnt_vld_s && (mode_s == MODE_RR)) begin
      ptr_r <= SEL_W'(wrap_inc(32'(gnt_idx_s), 32'(N)));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign bus.VALID_OUT = valid_r;
  assign bus.DATA_OUT  = data_r;
  assign bus.SRC_OUT   = src_r;

`ifdef MUX_GRANT_COUNT_EN
  logic [GRANT_CNT_W-1:0] cnt_r [N];

  // Per-input transfer counters; a transfer is exactly a set grant bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (gnt_oh_s[i]) begin
          cnt_r[i] <= cnt_r[i] + GRANT_CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cnt_out
    assign bus.GRANT_COUNT[gi*GRANT_CNT_W +: GRANT_CNT_W] = cnt_r[gi];
  end
`endif

endmodule
